// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage; sole driver of the register file write port.
// Latency: entry captured at edge N is written to the register file during cycle N, plus any stall cycles.
// Backpressure: in_ready drops only while a valid entry is held by wbStall; flush drops the incoming transfer.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_RegWrite,
  input  logic [1:0]       in_WbSel,
  input  logic [4:0]       in_writeReg,
  input  logic [XLEN-1:0]  in_aluResult,
  input  logic [XLEN-1:0]  in_memData,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic             flush,
  input  logic             wbStall,
  output logic             RegWrite,
  output logic [4:0]       writeReg,
  output logic [XLEN-1:0]  writeData,
  output logic             wbValid,
  output logic             loadErr,
  output logic [CNT_W-1:0] retired
);

  typedef struct packed {
    logic            rw;
    logic [1:0]      wbsel;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem;
    logic [XLEN-1:0] pc4;
  } stage_t;

  logic             r_valid;
  stage_t           r_stage;
  logic [CNT_W-1:0] r_retired;

  logic             w_accept;
  logic             w_retire;
  logic             w_err;
  logic             w_load_err;
  logic [1:0]       w_off;
  logic [XLEN-1:0]  w_shift;
  logic [XLEN-1:0]  w_load;
  logic [XLEN-1:0]  w_wb_data;

  assign in_ready = !r_valid || !wbStall;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_retire = r_valid && !wbStall;

  // Byte offset of the load comes from the low address bits carried in the ALU result.
  assign w_off   = r_stage.alu[1:0];
  assign w_shift = r_stage.mem >> {w_off, 3'b000};

  always_comb begin
    w_load     = '0;
    w_load_err = 1'b0;
    case (r_stage.funct3)
      3'b000: w_load = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
      3'b001: begin
        w_load     = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
        w_load_err = w_off[0];
      end
      3'b010: begin
        w_load     = r_stage.mem;
        w_load_err = (w_off != 2'b00);
      end
      3'b100: w_load = {{(XLEN-8){1'b0}}, w_shift[7:0]};
      3'b101: begin
        w_load     = {{(XLEN-16){1'b0}}, w_shift[15:0]};
        w_load_err = w_off[0];
      end
      default: w_load_err = 1'b1;
    endcase
  end

  assign w_err = (r_stage.wbsel == 2'b01) && w_load_err;

  always_comb begin
    w_wb_data = r_stage.alu;
    case (r_stage.wbsel)
      2'b01:   w_wb_data = w_load;
      2'b10:   w_wb_data = r_stage.pc4;
      default: w_wb_data = r_stage.alu;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_stage   <= '0;
      r_retired <= '0;
    end else begin
      if (w_accept) begin
        r_valid         <= 1'b1;
        r_stage.rw      <= in_RegWrite;
        r_stage.wbsel   <= in_WbSel;
        r_stage.rd      <= in_writeReg;
        r_stage.funct3  <= in_funct3;
        r_stage.alu     <= in_aluResult;
        r_stage.mem     <= in_memData;
        r_stage.pc4     <= in_pc4;
      end else if (w_retire) begin
        r_valid <= 1'b0;
      end
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  assign RegWrite  = w_retire && r_stage.rw && (r_stage.rd != 5'd0) && !w_err;
  assign writeReg  = r_stage.rd;
  assign writeData = w_wb_data;
  assign wbValid   = r_valid;
  assign loadErr   = w_retire && w_err;
  assign retired   = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table through a scoreboard, plus stall, flush and reset sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_RegWrite;
  logic [1:0]  in_WbSel;
  logic [4:0]  in_writeReg;
  logic [31:0] in_aluResult;
  logic [31:0] in_memData;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc4;
  logic        flush;
  logic        wbStall;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        wbValid;
  logic        loadErr;
  logic [31:0] retired;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_RegWrite(in_RegWrite), .in_WbSel(in_WbSel), .in_writeReg(in_writeReg),
    .in_aluResult(in_aluResult), .in_memData(in_memData), .in_funct3(in_funct3),
    .in_pc4(in_pc4), .flush(flush), .wbStall(wbStall),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .wbValid(wbValid), .loadErr(loadErr), .retired(retired)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  wbsel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [2:0]  f3;
    logic [31:0] pc4;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   n_writes = 0;
  vec_t sb[$];
  vec_t tab[18];

  function automatic vec_t mk(input logic rw, input logic [1:0] wbsel, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] f3,
                              input logic [31:0] pc4, input logic exp_we, input logic [31:0] exp_data,
                              input logic exp_err);
    vec_t v;
    v.rw = rw; v.wbsel = wbsel; v.rd = rd; v.alu = alu; v.mem = mem; v.f3 = f3; v.pc4 = pc4;
    v.exp_we = exp_we; v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic fl);
    @(posedge clk); #1;
    in_valid = 1'b1; in_RegWrite = v.rw; in_WbSel = v.wbsel; in_writeReg = v.rd;
    in_aluResult = v.alu; in_memData = v.mem; in_funct3 = v.f3; in_pc4 = v.pc4; flush = fl;
    if (!fl) begin
      sb.push_back(v);
      n_acc++;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_RegWrite"}, {31'd0, RegWrite}, 32'd0);
    check({tag, "_writeReg"}, {27'd0, writeReg}, 32'd0);
    check({tag, "_writeData"}, writeData, 32'd0);
    check({tag, "_wbValid"}, {31'd0, wbValid}, 32'd0);
    check({tag, "_loadErr"}, {31'd0, loadErr}, 32'd0);
    check({tag, "_retired"}, retired, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Scoreboard: every retire observed on the write port pops one expected entry.
  always @(negedge clk) begin
    if (reset_n) begin
      if (RegWrite) n_writes++;
      if (wbValid && !wbStall) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", {27'd0, writeReg}, 32'hFFFF_FFFF);
        end else begin
          vec_t e;
          e = sb.pop_front();
          check("sb_RegWrite", {31'd0, RegWrite}, {31'd0, e.exp_we});
          check("sb_writeReg", {27'd0, writeReg}, {27'd0, e.rd});
          check("sb_loadErr", {31'd0, loadErr}, {31'd0, e.exp_err});
          if (e.exp_we) check("sb_writeData", writeData, e.exp_data);
        end
      end else if (RegWrite || loadErr) begin
        check("spurious_write", {30'd0, RegWrite, loadErr}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    vec_t v;
    tab[0]  = mk(1, 2'b00, 5,  32'h0000_1234, 32'h0,         3'b000, 32'h0,   1, 32'h0000_1234, 0);
    tab[1]  = mk(1, 2'b01, 6,  32'h0000_0003, 32'h80FF_FF00, 3'b000, 32'h0,   1, 32'hFFFF_FF80, 0);
    tab[2]  = mk(1, 2'b01, 7,  32'h0000_0003, 32'h80FF_FF00, 3'b100, 32'h0,   1, 32'h0000_0080, 0);
    tab[3]  = mk(1, 2'b01, 8,  32'h0000_0002, 32'h80FF_FF00, 3'b001, 32'h0,   1, 32'hFFFF_80FF, 0);
    tab[4]  = mk(1, 2'b01, 9,  32'h0000_0002, 32'h80FF_FF00, 3'b101, 32'h0,   1, 32'h0000_80FF, 0);
    tab[5]  = mk(1, 2'b01, 10, 32'h0000_0000, 32'h1234_5678, 3'b010, 32'h0,   1, 32'h1234_5678, 0);
    tab[6]  = mk(1, 2'b01, 11, 32'h0000_0001, 32'h1234_5678, 3'b000, 32'h0,   1, 32'h0000_0056, 0);
    tab[7]  = mk(1, 2'b10, 12, 32'h0000_DEAD, 32'h0,         3'b000, 32'h104, 1, 32'h0000_0104, 0);
    tab[8]  = mk(1, 2'b11, 13, 32'h0000_0077, 32'hFFFF_FFFF, 3'b000, 32'h200, 1, 32'h0000_0077, 0);
    tab[9]  = mk(1, 2'b00, 0,  32'h0000_0055, 32'h0,         3'b000, 32'h0,   0, 32'h0000_0055, 0);
    tab[10] = mk(0, 2'b00, 14, 32'h0000_0099, 32'h0,         3'b000, 32'h0,   0, 32'h0000_0099, 0);
    tab[11] = mk(1, 2'b01, 15, 32'h0000_1002, 32'h1234_5678, 3'b010, 32'h0,   0, 32'h0,         1);
    tab[12] = mk(1, 2'b01, 16, 32'h0000_0001, 32'h1234_5678, 3'b001, 32'h0,   0, 32'h0,         1);
    tab[13] = mk(1, 2'b01, 17, 32'h0000_0000, 32'h1234_5678, 3'b011, 32'h0,   0, 32'h0,         1);
    tab[14] = mk(1, 2'b00, 18, 32'hFFFF_FFFF, 32'h0,         3'b000, 32'h0,   1, 32'hFFFF_FFFF, 0);
    tab[15] = mk(1, 2'b01, 19, 32'h0000_0000, 32'h0000_8000, 3'b001, 32'h0,   1, 32'hFFFF_8000, 0);
    tab[16] = mk(1, 2'b01, 20, 32'h0000_0000, 32'h1234_5678, 3'b110, 32'h0,   0, 32'h0,         1);
    tab[17] = mk(1, 2'b01, 21, 32'h0000_0002, 32'h80FF_FF00, 3'b100, 32'h0,   1, 32'h0000_00FF, 0);

    reset_n = 1'b0; in_valid = 1'b0; in_RegWrite = 1'b0; in_WbSel = 2'b00; in_writeReg = 5'd0;
    in_aluResult = 32'd0; in_memData = 32'd0; in_funct3 = 3'd0; in_pc4 = 32'd0;
    flush = 1'b0; wbStall = 1'b0;
    #3;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // First ALU write appears the cycle after capture and bumps the counter on retire.
    drive(tab[0], 1'b0);
    idle();
    @(posedge clk); #1;
    check("first_retired", retired, 32'd1);

    for (int i = 1; i < 18; i++) begin
      drive(tab[i], 1'b0);
      check("table_in_ready", {31'd0, in_ready}, 32'd1);
    end
    idle();
    repeat (3) @(posedge clk);
    #1 check("table_retired", retired, n_acc);

    // Stall a held entry for three cycles while new input is presented and must be refused.
    v = mk(1, 2'b00, 22, 32'h0000_ABCD, 32'h0, 3'b000, 32'h0, 1, 32'h0000_ABCD, 0);
    drive(v, 1'b0);
    @(posedge clk); #1;
    wbStall = 1'b1; in_writeReg = 5'd23; in_aluResult = 32'h5555_5555;
    w0 = n_writes;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_RegWrite", {31'd0, RegWrite}, 32'd0);
      check("stall_writeReg", {27'd0, writeReg}, 32'd22);
      check("stall_writeData", writeData, 32'h0000_ABCD);
    end
    @(posedge clk); #1;
    wbStall = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stall_one_write", n_writes - w0, 32'd1);
    check("stall_retired", retired, n_acc);

    // Eight back-to-back transfers; the fourth is flushed and must never be written.
    w0 = n_writes;
    for (int i = 0; i < 8; i++) begin
      v = mk(1, 2'b00, 5'(i + 1), 32'h100 + 32'(i), 32'h0, 3'b000, 32'h0, 1, 32'h100 + 32'(i), 0);
      drive(v, (i == 3));
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("b2b_writes", n_writes - w0, 32'd7);
    check("b2b_retired", retired, n_acc);
    check("b2b_sb_empty", sb.size(), 32'd0);

    // Reset asserted while an entry is held by a stall: it is discarded, never written.
    v = mk(1, 2'b00, 24, 32'h0000_CAFE, 32'h0, 3'b000, 32'h0, 1, 32'h0000_CAFE, 0);
    drive(v, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; wbStall = 1'b1;
    @(negedge clk);
    check("prereset_wbValid", {31'd0, wbValid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    sb.delete();
    w0 = n_writes;
    @(posedge clk); #1;
    reset_n = 1'b1; wbStall = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("postreset_no_write", n_writes - w0, 32'd0);
    check("postreset_retired", retired, 32'd0);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
